mant_div_seq: RTL and testbench
===============================

Name: mant_div_seq

Overview:
- Sequential radix-2 restoring divider for floating-point mantissas in the 2nd_division path.
- Produces one quotient bit per cycle. Each cycle it compares the partial remainder against the divisor MSB-first, greater/less/equal, and consumes that decision.
- Input mantissas are normalized and include the hidden bit.
- Outputs a quotient with one integer bit, plus a sticky bit for the downstream normalize/round stage.

Parameters:
- MW, 24, mantissa width including the hidden bit.
- QW, MW+2, quotient bits produced: 1 integer bit + (MW-1) fraction bits + guard + round.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request a divide; sampled only in IDLE.
- X  input  MW  dividend mantissa.
- Y  input  MW  divisor mantissa.
- BUSY  output  1  high in CALC and HOLD.
- OUT_VALID  output  1  result valid; high only in HOLD.
- OUT_READY  input  1  consumer accepts the result.
- Q_OUT  output  QW  quotient; bit QW-1 is the integer bit.
- STICKY  output  1  final remainder nonzero.
- DZ  output  1  divide by zero: Y[MW-1]==0.

Behaviour:
- Reset: while RST=1 at an edge, the FSM goes to IDLE.
  - BUSY=0, OUT_VALID=0, Q_OUT=0, STICKY=0, DZ=0.
  - Remainder, divisor and counter registers are cleared.
  - Reset overrides START and every in-flight operation. Reset in the middle of CALC abandons the operation and produces no result.
- States: IDLE, CALC, HOLD.
- IDLE, START=1 at an edge:
  - If Y[MW-1]==1: R <= {1'b0,X} (MW+1 bits), D <= Y, Q <= 0, CNT <= QW-1, DZ <= 0, go to CALC.
  - If Y[MW-1]==0: Q_OUT <= all ones, STICKY <= 0, DZ <= 1, go directly to HOLD.
- IDLE, START=0: stay in IDLE.
- CALC, each edge:
  - ge = (R >= D), unsigned compare on MW+1 bits with D zero-extended.
  - Q <= {Q[QW-2:0], ge}.
  - R <= (ge ? R-D : R) << 1, truncated to MW+1 bits. Truncation is lossless because R < 2D always holds.
  - CNT decrements. At the edge where CNT==0, go to HOLD with STICKY <= (next R != 0).
- Latency: OUT_VALID is first visible QW edges after the accepting edge (26 for the defaults). Divide by zero: 1 edge.
- HOLD:
  - Q_OUT, STICKY and DZ stay stable while OUT_VALID=1.
  - OUT_READY=1 at an edge: go to IDLE and drop OUT_VALID. Outputs keep their last values until the next accept.
- START outside IDLE is ignored, including in the cycle where HOLD hands off to IDLE. A new request is accepted earliest one edge after the handshake completes.
- Value range: with X and Y normalized, X/Y lies in (0.5, 2).
  - Q_OUT = floor(X/Y * 2^(QW-1)).
  - Q_OUT[QW-1]=0 means X<Y; the downstream stage shifts left by one.
- Q_OUT is registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: MANT_DIV_EARLY_TERM_EN.
- Defined:
  - In CALC, if the next R is zero, go to HOLD at that edge.
  - Q_OUT = the produced bits left-aligned, i.e. shifted left by the remaining count, with the lower bits zero. STICKY=0.
  - Latency becomes (number of bits produced) edges.
- Not defined: CALC always runs the full QW edges. Results are bit-identical in both builds; only latency differs.

Test Plan:
- 1.0/1.0: X=0x800000, Y=0x800000, START 1 cycle, OUT_READY=1.
  - Q_OUT=0x2000000, STICKY=0, DZ=0.
  - OUT_VALID 26 edges after accept; 1 edge with MANT_DIV_EARLY_TERM_EN.
- 1.5/1.0: X=0xC00000, Y=0x800000 -> Q_OUT=0x3000000, STICKY=0.
- 1.0/1.5: X=0x800000, Y=0xC00000.
  - Q_OUT=0x1555555, STICKY=1, OUT_VALID after 26 edges in both builds.
- Divide by zero: Y=0x000000, X=0x900000 -> DZ=1, Q_OUT=0x3FFFFFF, STICKY=0, OUT_VALID after 1 edge.
- Backpressure: hold OUT_READY=0 for 5 cycles in HOLD and pulse START with a new X/Y.
  - Outputs stay stable and the START is ignored.
  - OUT_READY=1 returns to IDLE, BUSY=0.
  - A following START is accepted normally.
- Reset mid-operation: assert RST at CALC cycle 10.
  - Next edge: BUSY=0, OUT_VALID=0, Q_OUT=0.
  - A fresh 1.5/1.0 then yields 0x3000000.

Source files
------------

// File: rtl/mant_div_seq.sv
// Sequential radix-2 restoring mantissa divider, one quotient bit per clock.
// Optional build macro MANT_DIV_EARLY_TERM_EN: stop as soon as the remainder reaches zero.
module mant_div_seq #(
  parameter int MW = 24,
  parameter int QW = MW + 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [MW-1:0] X,
  input  logic [MW-1:0] Y,
  output logic          BUSY,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [QW-1:0] Q_OUT,
  output logic          STICKY,
  output logic          DZ
);

  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [MW:0]   r_q, r_d;
  logic [MW-1:0] d_q, d_d;
  logic [QW-1:0] q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sticky_q, sticky_d;
  logic          dz_q, dz_d;

  logic          ge;
  logic [MW:0]   diff;
  logic [MW:0]   r_step;
  logic [QW-1:0] q_step;

  // R < 2D always holds, so the bit shifted out of r_step is always zero.
  assign ge     = (r_q >= {1'b0, d_q});
  assign diff   = ge ? (r_q - {1'b0, d_q}) : r_q;
  assign r_step = diff << 1;
  assign q_step = {q_q[QW-2:0], ge};

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    d_d      = d_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (Y[MW-1]) begin
            r_d     = {1'b0, X};
            d_d     = Y;
            q_d     = '0;
            cnt_d   = CNT_LAST;
            dz_d    = 1'b0;
            state_d = S_CALC;
          end else begin
            q_d      = '1;
            sticky_d = 1'b0;
            dz_d     = 1'b1;
            state_d  = S_HOLD;
          end
        end
      end
      S_CALC: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d  = S_HOLD;
          sticky_d = (r_step != '0);
        end
`ifdef MANT_DIV_EARLY_TERM_EN
        else if (r_step == '0) begin
          // Remaining quotient bits are all zero; left-align what was produced.
          state_d  = S_HOLD;
          q_d      = q_step << cnt_q;
          sticky_d = 1'b0;
        end
`endif
      end
      S_HOLD: begin
        if (OUT_READY) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      r_q      <= '0;
      d_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      d_q      <= d_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      dz_q     <= dz_d;
    end
  end

  assign BUSY      = (state_q == S_CALC) || (state_q == S_HOLD);
  assign OUT_VALID = (state_q == S_HOLD);
  assign Q_OUT     = q_q;
  assign STICKY    = sticky_q;
  assign DZ        = dz_q;

endmodule

// File: tb/tb_mant_div_seq.sv
// Self-checking bench for mant_div_seq: directed corner cases plus random
// normalized operands checked against an arithmetic reference model.
module tb_mant_div_seq;

  localparam int MW = 24;
  localparam int QW = MW + 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic [MW-1:0] X;
  logic [MW-1:0] Y;
  logic          BUSY;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [QW-1:0] Q_OUT;
  logic          STICKY;
  logic          DZ;

  int checks = 0;
  int errors = 0;

  mant_div_seq #(.MW(MW), .QW(QW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .X         (X),
    .Y         (Y),
    .BUSY      (BUSY),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .Q_OUT     (Q_OUT),
    .STICKY    (STICKY),
    .DZ        (DZ)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: quotient = floor(X * 2^(QW-1) / Y), remainder decides sticky.
  task automatic model(input logic [MW-1:0] x, input logic [MW-1:0] y,
                       output logic [QW-1:0] q, output logic s, output logic dz,
                       output int lat);
    logic [63:0] num;
    logic [63:0] quo;
    logic [63:0] rem;
    int          tz;
    if (!y[MW-1]) begin
      q   = '1;
      s   = 1'b0;
      dz  = 1'b1;
      lat = 0;
    end else begin
      num = {40'd0, x} << (QW - 1);
      quo = num / {40'd0, y};
      rem = num % {40'd0, y};
      q   = quo[QW-1:0];
      s   = (rem != 0);
      dz  = 1'b0;
      lat = QW;
`ifdef MANT_DIV_EARLY_TERM_EN
      if (rem == 0) begin
        tz = 0;
        while (tz < QW && quo[tz] == 1'b0) tz++;
        lat = QW - tz;
      end
`endif
    end
  endtask

  function automatic logic [MW-1:0] rand_norm();
    logic [31:0] r;
    r = $urandom;
    return {1'b1, r[MW-2:0]};
  endfunction

  task automatic do_div(input logic [MW-1:0] x, input logic [MW-1:0] y,
                        input int hold_cycles, input bit poke_start);
    logic [QW-1:0] eq;
    logic          es;
    logic          edz;
    int            elat;
    int            lat;
    model(x, y, eq, es, edz, elat);
    X = x;
    Y = y;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    if (elat > 0) chk("busy_calc", {63'd0, BUSY}, 64'd1);
    lat = 0;
    while (!OUT_VALID && lat < 200) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk("latency", lat, elat);
    chk("q_out", {38'd0, Q_OUT}, {38'd0, eq});
    chk("sticky", {63'd0, STICKY}, {63'd0, es});
    chk("dz", {63'd0, DZ}, {63'd0, edz});
    chk("busy_hold", {63'd0, BUSY}, 64'd1);
    for (int i = 0; i < hold_cycles; i++) begin
      if (poke_start && i == 2) begin
        X = rand_norm();
        Y = rand_norm();
        START = 1'b1;
      end
      @(posedge CLK); #1;
      START = 1'b0;
      chk("hold_valid", {63'd0, OUT_VALID}, 64'd1);
      chk("hold_q", {38'd0, Q_OUT}, {38'd0, eq});
      chk("hold_sticky", {63'd0, STICKY}, {63'd0, es});
      chk("hold_dz", {63'd0, DZ}, {63'd0, edz});
    end
    OUT_READY = 1'b1;
    START = poke_start;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    START = 1'b0;
    chk("handoff_valid", {63'd0, OUT_VALID}, 64'd0);
    chk("handoff_busy", {63'd0, BUSY}, 64'd0);
    chk("handoff_q_kept", {38'd0, Q_OUT}, {38'd0, eq});
    if (poke_start) begin
      @(posedge CLK); #1;
      chk("handoff_start_ignored", {63'd0, BUSY}, 64'd0);
    end
    $display("div X=%06h Y=%06h -> Q=%07h STICKY=%0b DZ=%0b lat=%0d (exp Q=%07h S=%0b DZ=%0b lat=%0d)",
             x, y, Q_OUT, STICKY, DZ, lat, eq, es, edz, elat);
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0;
    X = '0;
    Y = '0;
    OUT_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", {63'd0, BUSY}, 64'd0);
    chk("rst_valid", {63'd0, OUT_VALID}, 64'd0);
    chk("rst_q", {38'd0, Q_OUT}, 64'd0);
    chk("rst_sticky", {63'd0, STICKY}, 64'd0);
    chk("rst_dz", {63'd0, DZ}, 64'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    do_div(24'h800000, 24'h800000, 0, 1'b0);
    do_div(24'hC00000, 24'h800000, 1, 1'b0);
    do_div(24'h800000, 24'hC00000, 0, 1'b0);
    do_div(24'h900000, 24'h000000, 2, 1'b0);
    do_div(24'hC00000, 24'h800000, 5, 1'b1);
    do_div(24'h800000, 24'hC00000, 0, 1'b0);

    // Reset in the middle of a calculation abandons it.
    X = 24'hC00000;
    Y = 24'h800000;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("midrst_busy", {63'd0, BUSY}, 64'd0);
    chk("midrst_valid", {63'd0, OUT_VALID}, 64'd0);
    chk("midrst_q", {38'd0, Q_OUT}, 64'd0);
    $display("reset mid-operation: BUSY=%0b OUT_VALID=%0b Q=%07h", BUSY, OUT_VALID, Q_OUT);
    repeat (3) @(posedge CLK);
    #1;
    chk("midrst_stays_idle", {63'd0, OUT_VALID}, 64'd0);
    do_div(24'hC00000, 24'h800000, 0, 1'b0);

    for (int n = 0; n < 16; n++) begin
      do_div(rand_norm(), rand_norm(), $urandom_range(0, 3), 1'b0);
    end
    do_div(24'hFFFFFF, 24'h800000, 0, 1'b0);
    do_div(24'h800000, 24'hFFFFFF, 0, 1'b0);
    do_div(24'hABCDEF, 24'h7FFFFF, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
